// File: rtl/wb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// wb_mem_ctrl
// Wishbone classic slave that bridges single and wrapping-burst transfers onto
// a simple request/acknowledge 16-bit memory port.
//
// Parameters
//   MEM_AW  memory word-address width (depth 2^MEM_AW words, MEM_AW >= 3)
//   ADDR_W  Wishbone word-address width (ADDR_W > MEM_AW)
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   wb_cyc/stb/we/adr/i_dat/sel  bus master request
//   wb_4_burst, wb_8_burst    burst-length hints, sampled on acceptance
//   wb_o_dat/ack/err/rty      bus response (wb_rty tied low)
//   mem_req/we/addr/o_data/sel   memory request, held until mem_ack
//   mem_i_data, mem_ack       memory read data and one-cycle completion
//
// Optional feature
//   WB_MEM_BOUNDS_CHECK_EN    when defined, an address with any bit set above
//                             MEM_AW is rejected with wb_err and never reaches
//                             memory; when undefined those bits are ignored.
// -----------------------------------------------------------------------------
module wb_mem_ctrl #(
  parameter int MEM_AW = 16,
  parameter int ADDR_W = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_adr,
  input  logic [15:0]       wb_i_dat,
  input  logic [1:0]        wb_sel,
  input  logic              wb_4_burst,
  input  logic              wb_8_burst,
  output logic [15:0]       wb_o_dat,
  output logic              wb_ack,
  output logic              wb_err,
  output logic              wb_rty,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_o_data,
  output logic [1:0]        mem_sel,
  input  logic [15:0]       mem_i_data,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DRAIN = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [MEM_AW-1:0] adr_q, adr_d;       // burst start address
  logic [2:0]        mask_q, mask_d;     // N-1: 0, 3 or 7
  logic [2:0]        beat_q, beat_d;     // index of the beat in flight
  logic              gap_q, gap_d;       // set for the first cycle back in IDLE
  logic              wb_ack_q, wb_ack_d;
  logic              wb_err_q, wb_err_d;
  logic [15:0]       wb_o_dat_q, wb_o_dat_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_o_data_q, mem_o_data_d;
  logic [1:0]        mem_sel_q, mem_sel_d;

  logic [2:0]        n_mask;
  logic [2:0]        beat_nx;
  logic              oob;

  // Wrap within the aligned N-word block: only the low log2(N) bits advance.
  function automatic logic [MEM_AW-1:0] beat_addr(input logic [MEM_AW-1:0] base,
                                                  input logic [2:0]        mask,
                                                  input logic [2:0]        k);
    logic [2:0]        lo;
    logic [MEM_AW-1:0] a;
    lo     = base[2:0] + k;
    a      = base;
    a[2:0] = (base[2:0] & ~mask) | (lo & mask);
    return a;
  endfunction

  // A wrapping burst never changes bits above bit 2, so the upper-address
  // check only needs to be made once, at acceptance.
`ifdef WB_MEM_BOUNDS_CHECK_EN
  assign oob = |wb_adr[ADDR_W-1:MEM_AW];
`else
  assign oob = 1'b0;
  logic unused_adr_hi;
  assign unused_adr_hi = ^wb_adr[ADDR_W-1:MEM_AW];
`endif

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    mask_d       = mask_q;
    beat_d       = beat_q;
    gap_d        = 1'b0;
    wb_ack_d     = 1'b0;
    wb_err_d     = 1'b0;
    wb_o_dat_d   = wb_o_dat_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_o_data_d = mem_o_data_q;
    mem_sel_d    = mem_sel_q;
    n_mask       = wb_8_burst ? 3'd7 : (wb_4_burst ? 3'd3 : 3'd0);
    beat_nx      = beat_q + 3'd1;

    case (state_q)
      IDLE: begin
        if (!gap_q && wb_cyc && wb_stb) begin
          if ((wb_we && n_mask != 3'd0) || oob) begin
            // Burst writes and out-of-range addresses never touch memory.
            wb_err_d = 1'b1;
            gap_d    = 1'b1;
          end else begin
            adr_d        = wb_adr[MEM_AW-1:0];
            mask_d       = n_mask;
            beat_d       = 3'd0;
            mem_req_d    = 1'b1;
            mem_we_d     = wb_we;
            mem_addr_d   = wb_adr[MEM_AW-1:0];
            mem_o_data_d = wb_i_dat;
            mem_sel_d    = wb_sel;
            state_d      = REQ;
          end
        end
      end

      REQ: begin
        if (!wb_cyc) begin
          // Master gave up; finish the memory handshake silently.
          if (mem_ack) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            gap_d     = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else if (mem_ack) begin
          wb_o_dat_d = mem_i_data;
          wb_ack_d   = 1'b1;
          state_d    = RESP;
          if (beat_q != mask_q) begin
            // Next beat's request goes out alongside this beat's ack.
            beat_d     = beat_nx;
            mem_addr_d = beat_addr(adr_q, mask_q, beat_nx);
          end else begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
          end
        end
      end

      RESP: begin
        if (!wb_cyc || !mem_req_q) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          gap_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = REQ;
        end
      end

      DRAIN: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          gap_d     = 1'b1;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      adr_q        <= '0;
      mask_q       <= '0;
      beat_q       <= '0;
      gap_q        <= 1'b0;
      wb_ack_q     <= 1'b0;
      wb_err_q     <= 1'b0;
      wb_o_dat_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_o_data_q <= '0;
      mem_sel_q    <= '0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      mask_q       <= mask_d;
      beat_q       <= beat_d;
      gap_q        <= gap_d;
      wb_ack_q     <= wb_ack_d;
      wb_err_q     <= wb_err_d;
      wb_o_dat_q   <= wb_o_dat_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_o_data_q <= mem_o_data_d;
      mem_sel_q    <= mem_sel_d;
    end
  end

  // If the master drops wb_cyc in RESP, the ack and the already-issued next
  // request are withdrawn in that same cycle so neither side sees them.
  logic resp_abort;
  assign resp_abort = (state_q == RESP) && !wb_cyc;

  assign wb_ack     = wb_ack_q && !resp_abort;
  assign wb_err     = wb_err_q;
  assign wb_rty     = 1'b0;
  assign wb_o_dat   = wb_o_dat_q;
  assign mem_req    = mem_req_q && !resp_abort;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_o_data = mem_o_data_q;
  assign mem_sel    = mem_sel_q;

endmodule

// File: doc/wb_mem_ctrl.md
WB_MEM_CTRL -- requirements
Module: wb_mem_ctrl

Interface
REQ-001 Parameter MEM_AW, default 16, SHALL set the memory word-address width (memory depth 2^MEM_AW 16-bit words).
REQ-002 Parameter ADDR_W, default 24, SHALL set the Wishbone word-address width.
REQ-003 i_clk  in  1  single clock; all state SHALL update on its rising edge only.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 wb_cyc, wb_stb, wb_we  in  1 each  Wishbone classic cycle, strobe and write-enable from the bus master.
REQ-006 wb_adr  in  ADDR_W  word address; wb_i_dat  in  16  write data; wb_sel  in  2  byte lanes.
REQ-007 wb_4_burst, wb_8_burst  in  1 each  burst-length hints, sampled only when a transaction is accepted.
REQ-008 wb_o_dat  out  16  read data; wb_ack, wb_err, wb_rty  out  1 each  beat acknowledge, error, retry (wb_rty SHALL be constant 0).
REQ-009 mem_req, mem_we  out  1 each; mem_addr  out  MEM_AW; mem_o_data  out  16; mem_sel  out  2  memory-side request.
REQ-010 mem_i_data  in  16; mem_ack  in  1  memory completion, valid for exactly one cycle per request, earliest 1 cycle after mem_req.

Function
REQ-011 FSM states SHALL be IDLE, REQ, RESP and DRAIN.
REQ-012 IDLE: when wb_cyc&wb_stb=1, the block SHALL latch wb_adr, wb_we, wb_i_dat and wb_sel, set beat count N (8 if wb_8_burst, else 4 if wb_4_burst, else 1; both set -> 8), and go to REQ.
REQ-013 REQ: mem_req SHALL be held at 1 with stable mem_addr, mem_we, mem_o_data and mem_sel until mem_ack; on mem_ack it SHALL register mem_i_data into wb_o_dat and go to RESP.
REQ-014 RESP: wb_ack SHALL be 1 for exactly one cycle per beat; wb_o_dat SHALL be stable in that cycle.
REQ-015 On a non-final beat, RESP SHALL issue the next mem_req in the same cycle as wb_ack and return to REQ; after the final beat it SHALL go to IDLE.
REQ-016 Per-beat latency SHALL be (memory latency + 1) cycles; a single read with a 1-cycle memory SHALL ack 3 cycles after acceptance.
REQ-017 Beat k address SHALL be the start address with the low log2(N) bits replaced by (start low bits + k) mod N, i.e. the burst wraps within its aligned N-word block (start 0x...6 with N=8 gives 6,7,0,1,...,5).
REQ-018 mem_addr SHALL be the low MEM_AW bits of the beat address.
REQ-019 A write with N>1 SHALL NOT access memory; wb_err SHALL be 1 for one cycle, 1 cycle after acceptance, and the FSM SHALL return to IDLE.
REQ-020 A single write SHALL drive mem_we=1 and mem_sel=wb_sel; wb_ack SHALL follow mem_ack as for reads; wb_o_dat SHALL be don't-care.
REQ-021 If wb_cyc falls while in REQ, the block SHALL enter DRAIN, keep mem_req asserted until mem_ack, discard the data, assert no wb_ack, then go to IDLE.
REQ-022 If wb_cyc is 0 in RESP, the pending ack SHALL be suppressed and the FSM SHALL go to IDLE.
REQ-023 A transaction SHALL NOT be accepted in the cycle the FSM returns to IDLE; acceptance is re-evaluated on the next cycle, giving back-to-back transactions a 1-cycle gap.
REQ-024 wb_ack and wb_err SHALL never be 1 in the same cycle.

Reset
REQ-025 While i_rst=1: state SHALL be IDLE and wb_ack, wb_err, wb_rty, mem_req and mem_we SHALL be 0; wb_o_dat, mem_addr, mem_o_data and mem_sel SHALL be 0.
REQ-026 Reset during any state, including mid-burst or DRAIN, SHALL take effect at the next edge with no ack; a late mem_ack arriving after reset SHALL be ignored.

Configuration
REQ-027 Macro WB_MEM_BOUNDS_CHECK_EN defined: any beat whose address has nonzero bits above MEM_AW SHALL skip memory, assert wb_err for one cycle instead of wb_ack, and end the transaction.
REQ-028 Macro WB_MEM_BOUNDS_CHECK_EN undefined: upper address bits SHALL be ignored (memory aliases) and wb_err SHALL only arise from REQ-019.

Verification
REQ-029 Single read at addr 0x000010, memory holding 0xBEEF, 1-cycle memory -> wb_ack 3 cycles after acceptance with wb_o_dat=0xBEEF.
REQ-030 8-burst read starting at 0x000006 -> mem_addr sequence 6,7,0,1,2,3,4,5 and eight wb_ack pulses with matching data.
REQ-031 Single write 0x1234, wb_sel=2'b01, addr 0x20 -> mem_we=1, mem_sel=01, one wb_ack; readback returns 0x34 in the low byte and the high byte unchanged.
REQ-032 4-burst write -> wb_err pulse 1 cycle after acceptance, no mem_req, no wb_ack.
REQ-033 wb_cyc dropped while beat 3 of an 8-burst is in REQ, memory latency 4 -> mem_req held until mem_ack, no further wb_ack, IDLE afterwards; the next transaction is served correctly.
REQ-034 With WB_MEM_BOUNDS_CHECK_EN defined, read at 0x010000 (MEM_AW=16) -> wb_err, no mem_req; without it -> reads the word at address 0x0000.
